rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: address filtering, length checking and buffer writes
// for src/dst/len/payload/crc frames, with per-frame status pulses.
module rx_frame_ctrl #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MAX_LEN = 253
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        filter,
  input  logic              promisc,
  input  logic              bus_idle,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_clk,
  input  logic [15:0]       crc_data,
  input  logic              buf_free,
  input  logic              abort,
  output logic              force_wait_idle,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic [8:0]        frame_len,
  output logic              crc_err,
  output logic              len_err,
  output logic              lost
);

  localparam int unsigned CNT_W = 9;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         len_q, len_d;

  logic               fwi_d, wr_en_d, done_d, crc_err_d, len_err_d, lost_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [7:0]         wr_data_d;
  logic [8:0]         frame_len_d;

  logic [CNT_W-1:0]   len_ext;
  logic               dst_ok;
  logic               crc_hi;

  assign len_ext = CNT_W'(len_q);
  assign dst_ok  = promisc || (rx_data == filter) || (rx_data == 8'hFF);
  // Length byte is known once three bytes are in, so the crc_hi index is valid only past that point.
  assign crc_hi  = (cnt_q > CNT_W'(2)) && (cnt_q == len_ext + CNT_W'(4));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      len_q           <= '0;
      force_wait_idle <= 1'b0;
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      frame_done      <= 1'b0;
      frame_len       <= '0;
      crc_err         <= 1'b0;
      len_err         <= 1'b0;
      lost            <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      len_q           <= len_d;
      force_wait_idle <= fwi_d;
      wr_en           <= wr_en_d;
      wr_addr         <= wr_addr_d;
      wr_data         <= wr_data_d;
      frame_done      <= done_d;
      frame_len       <= frame_len_d;
      crc_err         <= crc_err_d;
      len_err         <= len_err_d;
      lost            <= lost_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    fwi_d       = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    done_d      = 1'b0;
    frame_len_d = '0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    lost_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_data_clk) begin
          if (buf_free) begin
            wr_en_d   = 1'b1;
            wr_data_d = rx_data;
            cnt_d     = CNT_W'(1);
            state_d   = RECV;
          end else begin
            lost_d  = 1'b1;
            state_d = DROP;
          end
        end
      end

      RECV: begin
        if (abort) begin
          fwi_d   = 1'b1;
          state_d = IDLE;
        end else if (rx_data_clk && crc_hi) begin
          if (crc_data == 16'h0000) begin
            done_d      = 1'b1;
            frame_len_d = len_ext + CNT_W'(3);
          end else begin
            crc_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (bus_idle) begin
          len_err_d = 1'b1;
          state_d   = IDLE;
        end else if (rx_data_clk) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Header bytes are always stored; payload only up to the declared length.
          if (cnt_q <= CNT_W'(2) || cnt_q <= len_ext + CNT_W'(2)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(cnt_q);
            wr_data_d = rx_data;
          end
          if (cnt_q == CNT_W'(1) && !dst_ok) begin
            state_d = DROP;
          end
          if (cnt_q == CNT_W'(2)) begin
            len_d = rx_data;
            if (32'(rx_data) > MAX_LEN) begin
              len_err_d = 1'b1;
              fwi_d     = 1'b1;
              state_d   = DROP;
            end
          end
        end
      end

      DROP: begin
        if (abort) begin
          fwi_d   = 1'b1;
          state_d = IDLE;
        end else if (bus_idle) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed table-driven bench for rx_frame_ctrl plus a hand-written frame with
// a bounded wait for completion.
module tb_rx_frame_ctrl;

  localparam int unsigned ADDR_W = 9;
  localparam logic [4:0] P_DONE = 5'b10000;
  localparam logic [4:0] P_CRC  = 5'b01000;
  localparam logic [4:0] P_LEN  = 5'b00100;
  localparam logic [4:0] P_LOST = 5'b00010;
  localparam logic [4:0] P_FWI  = 5'b00001;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        filter;
  logic              promisc;
  logic              bus_idle;
  logic [7:0]        rx_data;
  logic              rx_data_clk;
  logic [15:0]       crc_data;
  logic              buf_free;
  logic              abort;
  logic              force_wait_idle;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done;
  logic [8:0]        frame_len;
  logic              crc_err;
  logic              len_err;
  logic              lost;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  rx_frame_ctrl #(.ADDR_W(ADDR_W), .MAX_LEN(253)) dut (
    .clk(clk), .reset_n(reset_n), .filter(filter), .promisc(promisc),
    .bus_idle(bus_idle), .rx_data(rx_data), .rx_data_clk(rx_data_clk),
    .crc_data(crc_data), .buf_free(buf_free), .abort(abort),
    .force_wait_idle(force_wait_idle), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .frame_len(frame_len),
    .crc_err(crc_err), .len_err(len_err), .lost(lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en) wr_count++;

  typedef struct {
    string       name;
    logic        rst;
    logic        stb;
    logic [7:0]  d;
    logic [15:0] crc;
    logic        idl;
    logic        ab;
    logic        bf;
    logic        pr;
    logic        we;
    logic [8:0]  a;
    logic [7:0]  wd;
    logic [4:0]  p;
    logic [8:0]  fl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic rst, input logic stb, input logic [7:0] d,
                     input logic [15:0] crc, input logic idl, input logic ab, input logic bf,
                     input logic pr, input logic we, input logic [8:0] a, input logic [4:0] p,
                     input logic [8:0] fl);
    vec_t v;
    v.name = n; v.rst = rst; v.stb = stb; v.d = d; v.crc = crc; v.idl = idl; v.ab = ab;
    v.bf = bf; v.pr = pr; v.we = we; v.a = a; v.wd = we ? d : 8'h00; v.p = p; v.fl = fl;
    vecs.push_back(v);
  endtask

  task automatic nop(input string n);
    add(n, 1, 0, 8'h00, 16'h0, 0, 0, 1, 0, 0, 9'd0, 5'b0, 9'd0);
  endtask

  task automatic byt(input string n, input logic [7:0] d, input logic [15:0] crc, input logic we,
                     input logic [8:0] a, input logic [4:0] p, input logic [8:0] fl);
    add(n, 1, 1, d, crc, 0, 0, 1, 0, we, a, p, fl);
  endtask

  task automatic drive(input vec_t v);
    reset_n = v.rst; rx_data_clk = v.stb; rx_data = v.d; crc_data = v.crc;
    bus_idle = v.idl; abort = v.ab; buf_free = v.bf; promisc = v.pr;
  endtask

  task automatic check(input string n, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {we,addr,data,done,crc,len,lost,fwi,flen}=%h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [39:0] outs();
    return {wr_en, wr_addr, wr_data, frame_done, crc_err, len_err, lost, force_wait_idle, frame_len};
  endfunction

  task automatic send(input logic [7:0] d, input logic [15:0] crc);
    vec_t v;
    v.rst = 1; v.stb = 1; v.d = d; v.crc = crc; v.idl = 0; v.ab = 0; v.bf = 1; v.pr = 0;
    drive(v);
    @(posedge clk); #1;
    rx_data_clk = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    filter = 8'h05;
    // Reset and a good frame.
    add("rst", 0, 0, 8'h00, 16'h0, 0, 0, 1, 0, 0, 9'd0, 5'b0, 9'd0);
    nop("idle0");
    byt("f1_src", 8'h01, 16'h1111, 1, 9'd0, 5'b0, 9'd0);
    nop("f1_gap");
    byt("f1_dst", 8'h05, 16'h2222, 1, 9'd1, 5'b0, 9'd0);
    byt("f1_len", 8'h02, 16'h3333, 1, 9'd2, 5'b0, 9'd0);
    byt("f1_p0", 8'hAA, 16'h4444, 1, 9'd3, 5'b0, 9'd0);
    nop("f1_gap2");
    byt("f1_p1", 8'hBB, 16'h5555, 1, 9'd4, 5'b0, 9'd0);
    byt("f1_crclo", 8'h12, 16'h6666, 0, 9'd0, 5'b0, 9'd0);
    byt("f1_crchi", 8'h34, 16'h0000, 0, 9'd0, P_DONE, 9'd5);
    nop("f1_after");
    // CRC failure.
    byt("f2_src", 8'h01, 16'h1111, 1, 9'd0, 5'b0, 9'd0);
    byt("f2_dst", 8'h05, 16'h1111, 1, 9'd1, 5'b0, 9'd0);
    byt("f2_len", 8'h02, 16'h1111, 1, 9'd2, 5'b0, 9'd0);
    byt("f2_p0", 8'hAA, 16'h1111, 1, 9'd3, 5'b0, 9'd0);
    byt("f2_p1", 8'hBB, 16'h1111, 1, 9'd4, 5'b0, 9'd0);
    byt("f2_crclo", 8'h12, 16'h1111, 0, 9'd0, 5'b0, 9'd0);
    byt("f2_crchi", 8'hB4, 16'h0080, 0, 9'd0, P_CRC, 9'd0);
    nop("f2_after");
    // Filtered destination.
    byt("f3_src", 8'h01, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    byt("f3_dst", 8'h07, 16'h1, 1, 9'd1, 5'b0, 9'd0);
    byt("f3_len", 8'h02, 16'h1, 0, 9'd0, 5'b0, 9'd0);
    byt("f3_p0", 8'hAA, 16'h1, 0, 9'd0, 5'b0, 9'd0);
    add("f3_idle", 1, 0, 8'h00, 16'h0, 1, 0, 1, 0, 0, 9'd0, 5'b0, 9'd0);
    nop("f3_after");
    // Oversized length.
    byt("f4_src", 8'h01, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    byt("f4_dst", 8'h05, 16'h1, 1, 9'd1, 5'b0, 9'd0);
    byt("f4_len", 8'hFE, 16'h1, 1, 9'd2, P_LEN | P_FWI, 9'd0);
    byt("f4_drop", 8'h00, 16'h0, 0, 9'd0, 5'b0, 9'd0);
    add("f4_idle", 1, 0, 8'h00, 16'h0, 1, 0, 1, 0, 0, 9'd0, 5'b0, 9'd0);
    // No buffer, then accepted frame with buf_free dropping mid-frame and max length.
    add("f5_lost", 1, 1, 8'h01, 16'h1, 0, 0, 0, 0, 0, 9'd0, P_LOST, 9'd0);
    byt("f5_drop", 8'h05, 16'h1, 0, 9'd0, 5'b0, 9'd0);
    add("f5_idle", 1, 0, 8'h00, 16'h0, 1, 0, 1, 0, 0, 9'd0, 5'b0, 9'd0);
    byt("f6_src", 8'h01, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    add("f6_dst_nobuf", 1, 1, 8'h05, 16'h1, 0, 0, 0, 0, 1, 9'd1, 5'b0, 9'd0);
    byt("f6_len_max", 8'hFD, 16'h1, 1, 9'd2, 5'b0, 9'd0);
    add("f6_abort", 1, 0, 8'h00, 16'h0, 0, 1, 1, 0, 0, 9'd0, P_FWI, 9'd0);
    nop("f6_after");
    // Truncated frame.
    byt("f7_src", 8'h01, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    byt("f7_dst", 8'h05, 16'h1, 1, 9'd1, 5'b0, 9'd0);
    byt("f7_len", 8'h02, 16'h1, 1, 9'd2, 5'b0, 9'd0);
    byt("f7_p0", 8'hAA, 16'h1, 1, 9'd3, 5'b0, 9'd0);
    add("f7_trunc", 1, 0, 8'h00, 16'h0, 1, 0, 1, 0, 0, 9'd0, P_LEN, 9'd0);
    nop("f7_after");
    // Abort wins over a coincident strobe.
    byt("f8_src", 8'h01, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    byt("f8_dst", 8'h05, 16'h1, 1, 9'd1, 5'b0, 9'd0);
    add("f8_abort", 1, 1, 8'h02, 16'h1, 0, 1, 1, 0, 0, 9'd0, P_FWI, 9'd0);
    // Promiscuous zero-length frame, crc_hi coincident with bus_idle.
    byt("f9_src", 8'h01, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    add("f9_dst", 1, 1, 8'h09, 16'h1, 0, 0, 1, 1, 1, 9'd1, 5'b0, 9'd0);
    byt("f9_len", 8'h00, 16'h1, 1, 9'd2, 5'b0, 9'd0);
    byt("f9_crclo", 8'h11, 16'h1, 0, 9'd0, 5'b0, 9'd0);
    add("f9_crchi", 1, 1, 8'h22, 16'h0000, 1, 0, 1, 0, 0, 9'd0, P_DONE, 9'd3);
    // Broadcast destination with bad CRC.
    byt("f10_src", 8'h01, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    byt("f10_dst", 8'hFF, 16'h1, 1, 9'd1, 5'b0, 9'd0);
    byt("f10_len", 8'h00, 16'h1, 1, 9'd2, 5'b0, 9'd0);
    byt("f10_crclo", 8'h11, 16'h1, 0, 9'd0, 5'b0, 9'd0);
    byt("f10_crchi", 8'h22, 16'h0001, 0, 9'd0, P_CRC, 9'd0);
    // Reset mid-frame clears counter silently.
    byt("f11_src", 8'h01, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    byt("f11_dst", 8'h05, 16'h1, 1, 9'd1, 5'b0, 9'd0);
    add("f11_rst", 0, 1, 8'h02, 16'h1, 0, 0, 1, 0, 0, 9'd0, 5'b0, 9'd0);
    byt("f11_restart", 8'h07, 16'h1, 1, 9'd0, 5'b0, 9'd0);
    add("f11_rst2", 0, 0, 8'h00, 16'h0, 0, 0, 1, 0, 0, 9'd0, 5'b0, 9'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check(vecs[i].name, outs(),
            {vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].p, vecs[i].fl});
    end

    // Hand-written frame with gaps: 01 05 01 77 crc; bounded wait for completion.
    begin
      int n;
      logic seen;
      reset_n = 1'b1; abort = 1'b0; bus_idle = 1'b0; buf_free = 1'b1; promisc = 1'b0;
      rx_data_clk = 1'b0;
      @(posedge clk); #1;
      wr_count = 0;
      send(8'h01, 16'h9999);
      send(8'h05, 16'h9999);
      send(8'h01, 16'h9999);
      send(8'h77, 16'h9999);
      send(8'h10, 16'h9999);
      rx_data_clk = 1'b1; rx_data = 8'h20; crc_data = 16'h0000;
      seen = 1'b0;
      for (n = 0; n < 8 && !seen; n++) begin
        @(posedge clk); #1;
        rx_data_clk = 1'b0;
        if (frame_done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL hs_done_timeout: frame_done not seen, expected within 8 cycles");
      end else begin
        check("hs_flen", {31'd0, frame_len}, {31'd0, 9'd4});
        check("hs_latency", 40'(n), 40'd1);
      end
      @(posedge clk); #1;
      check("hs_done_oneshot", {39'd0, frame_done}, 40'd0);
      check("hs_writes", 40'(wr_count), 40'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
